// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file write-back queue.
package wb_pkg;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] wreg;
        logic [DATA_W-1:0] data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// In-order circular buffer of write-back entries: up to two pushes and one pop per cycle.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_a,
    input  wb_entry_t                  din_a,
    input  logic                       push_b,
    input  wb_entry_t                  din_b,
    input  logic                       pop,
    output logic [$clog2(DEPTH):0]     count,
    output wb_entry_t                  head_entry,
    output wb_entry_t [DEPTH-1:0]      entries,
    output logic [DEPTH-1:0]           entry_vld
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] head, tail, tail_b, off;
    logic          do_pop;

    assign do_pop     = pop && (count != '0);
    // When both push, din_b lands one slot behind din_a so order is preserved
    assign tail_b     = push_a ? tail + PW'(1) : tail;
    assign head_entry = entries[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_a) entries[tail]   <= din_a;
            if (push_b) entries[tail_b] <= din_b;
            tail  <= tail + PW'(push_a) + PW'(push_b);
            if (do_pop) head <= head + PW'(1);
            count <= count + CW'(push_a) + CW'(push_b) - CW'(do_pop);
        end
    end

    // Slot i holds live data when its distance from head is below the occupancy
    always_comb begin
        off       = '0;
        entry_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - head;
            entry_vld[i] = ({1'b0, off} < count);
        end
    end
endmodule

// File: rtl/writeback_queue.sv
// Write-back stage: arbitrates load/ALU results into an in-order queue and
// retires one register-file write per cycle, publishing a pending-register mask.
module writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int ADDR_W = wb_pkg::ADDR_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [ADDR_W-1:0]       mem_reg,
    input  logic [DATA_W-1:0]       mem_data,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [ADDR_W-1:0]       alu_reg,
    input  logic [DATA_W-1:0]       alu_data,
    output logic                    regWrite,
    output logic [ADDR_W-1:0]       writeReg,
    output logic [DATA_W-1:0]       writeData,
    output logic [31:0]             pending,
    output logic [$clog2(DEPTH):0]  count
);
    import wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]         free;
    logic                  mem_push, alu_push, push_a, push_b, pop;
    wb_entry_t             mem_e, alu_e, din_a, head_e;
    wb_entry_t [DEPTH-1:0] entries;
    logic [DEPTH-1:0]      entry_vld;

    // Free space ignores the same-cycle pop; conservative but keeps ready off the pop path
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = (free != '0);
    assign alu_ready = (free >= CW'(2)) || ((free != '0) && !mem_valid);

    // r0 writes complete the handshake but are dropped here
    assign mem_push = mem_valid && mem_ready && (mem_reg != REG_ZERO);
    assign alu_push = alu_valid && alu_ready && (alu_reg != REG_ZERO);

    assign mem_e = wb_entry_t'{wreg: mem_reg, data: mem_data};
    assign alu_e = wb_entry_t'{wreg: alu_reg, data: alu_data};

    // Compact so the older (mem) write always takes the first slot
    assign push_a = mem_push || alu_push;
    assign din_a  = mem_push ? mem_e : alu_e;
    assign push_b = mem_push && alu_push;

    assign pop = (count != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_a     (push_a),
        .din_a      (din_a),
        .push_b     (push_b),
        .din_b      (alu_e),
        .pop        (pop),
        .count      (count),
        .head_entry (head_e),
        .entries    (entries),
        .entry_vld  (entry_vld)
    );

    assign regWrite  = pop;
    assign writeReg  = pop ? head_e.wreg : '0;
    assign writeData = pop ? head_e.data : '0;

    always_comb begin
        pending = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entry_vld[i]) pending[entries[i].wreg] = 1'b1;
        pending[0] = 1'b0;
    end
endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_writeback_queue;
    localparam int DEPTH  = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int CW     = $clog2(DEPTH) + 1;

    typedef struct {
        logic [ADDR_W-1:0] r;
        logic [DATA_W-1:0] d;
    } item_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              mem_valid = 1'b0, alu_valid = 1'b0;
    logic              mem_ready, alu_ready;
    logic [ADDR_W-1:0] mem_reg = '0, alu_reg = '0;
    logic [DATA_W-1:0] mem_data = '0, alu_data = '0;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [31:0]       pending;
    logic [CW-1:0]     count;

    always #5 clk = ~clk;

    writeback_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData),
        .pending(pending), .count(count)
    );

    item_t mdl_q[$];
    item_t msrc[$];
    item_t asrc[$];
    int    total = 0;
    int    bad   = 0;
    bit    en_m  = 1'b0;
    bit    en_a  = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic item_t mk(input int r, input logic [DATA_W-1:0] d);
        item_t it;
        it.r = ADDR_W'(r);
        it.d = d;
        return it;
    endfunction

    // One clock: present source heads, check outputs mid-cycle, advance model at the edge.
    task automatic tick();
        int                free_v;
        bit                er_m, er_a;
        logic [31:0]       pm;
        logic [ADDR_W-1:0] exp_reg;
        logic [DATA_W-1:0] exp_data;

        mem_valid = en_m && (msrc.size() > 0);
        alu_valid = en_a && (asrc.size() > 0);
        mem_reg   = mem_valid ? msrc[0].r : ADDR_W'($urandom);
        mem_data  = mem_valid ? msrc[0].d : $urandom;
        alu_reg   = alu_valid ? asrc[0].r : ADDR_W'($urandom);
        alu_data  = alu_valid ? asrc[0].d : $urandom;

        free_v = DEPTH - mdl_q.size();
        er_m   = (free_v >= 1);
        er_a   = (free_v >= 2) || (free_v >= 1 && !mem_valid);
        pm     = '0;
        foreach (mdl_q[k]) if (mdl_q[k].r != 0) pm[mdl_q[k].r] = 1'b1;
        exp_reg  = '0;
        exp_data = '0;
        if (mdl_q.size() > 0) begin
            exp_reg  = mdl_q[0].r;
            exp_data = mdl_q[0].d;
        end

        @(negedge clk);
        chk("mem_ready", mem_ready, er_m);
        chk("alu_ready", alu_ready, er_a);
        chk("count", count, mdl_q.size());
        chk("regWrite", regWrite, mdl_q.size() > 0);
        chk("writeReg", writeReg, exp_reg);
        chk("writeData", writeData, exp_data);
        chk("pending", pending, pm);

        @(posedge clk);
        if (rst) begin
            mdl_q.delete();
        end else begin
            if (mdl_q.size() > 0) void'(mdl_q.pop_front());
            if (mem_valid && er_m) begin
                if (mem_reg != 0) mdl_q.push_back(mk(mem_reg, mem_data));
                void'(msrc.pop_front());
            end
            if (alu_valid && er_a) begin
                if (alu_reg != 0) mdl_q.push_back(mk(alu_reg, alu_data));
                void'(asrc.pop_front());
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tick();                      // reset state visible while rst held
        rst  = 1'b0;
        en_m = 1'b1;
        en_a = 1'b1;

        // single load write
        msrc.push_back(mk(5, 32'hDEADBEEF));
        run(3);

        // dual push to the same register: mem retires first
        msrc.push_back(mk(3, 32'h11));
        asrc.push_back(mk(3, 32'h22));
        run(4);

        // fill with interleaved regs 1..8
        for (int i = 0; i < 4; i++) begin
            msrc.push_back(mk(2 * i + 1, 32'hA000 + i));
            asrc.push_back(mk(2 * i + 2, 32'hB000 + i));
        end
        run(12);

        // r0 write is acknowledged but never retires
        asrc.push_back(mk(0, 32'hFFFFFFFF));
        run(3);

        // reset with entries queued
        msrc.push_back(mk(9, 32'h9));
        msrc.push_back(mk(10, 32'hA));
        asrc.push_back(mk(11, 32'hB));
        asrc.push_back(mk(12, 32'hC));
        run(2);
        en_m = 1'b0;
        en_a = 1'b0;
        rst  = 1'b1;
        tick();
        rst  = 1'b0;
        tick();
        msrc.delete();
        asrc.delete();
        en_m = 1'b1;
        en_a = 1'b1;
        msrc.push_back(mk(7, 32'h77));
        run(3);

        // reach count=3 with both sources valid so only mem fits
        for (int i = 0; i < 3; i++) begin
            msrc.push_back(mk(13 + i, 32'hC0 + i));
            asrc.push_back(mk(20 + i, 32'hD0 + i));
        end
        run(10);

        // random traffic with occasional resets
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 2) == 0 && msrc.size() < 4)
                msrc.push_back(mk($urandom_range(0, 31), $urandom));
            if ($urandom_range(0, 2) == 0 && asrc.size() < 4)
                asrc.push_back(mk($urandom_range(0, 31), $urandom));
            en_m = ($urandom_range(0, 3) != 0);
            en_a = ($urandom_range(0, 3) != 0);
            rst  = ($urandom_range(0, 99) == 0);
            if (rst) begin
                en_m = 1'b0;
                en_a = 1'b0;
            end
            tick();
        end
        rst  = 1'b0;
        en_m = 1'b1;
        en_a = 1'b1;
        run(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
